hv_bundle: RTL and testbench

- Downstream consumer of the permute stage in the HPU datapath.
- Takes each rotated hypervector, optionally binds it (XOR) with a second vector, and accumulates per-bit ones-counts across a sequence.
- On the last vector of a sequence, produces the bit-wise majority (bundled) hypervector.
- Uses the same exec stall semantics as the permute pipeline, so the controller can freeze both blocks together.

---
 rtl/hpu_pkg.sv | 34 +++
 rtl/hv_bundle_bit_counter.sv | 41 ++++
 rtl/hv_bundle.sv | 157 +++++++++++++++
 tb/tb_hv_bundle.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpu_pkg.sv
// Shared HPU definitions: default dimensions, the bundle state encoding and
// the per-bit majority decision used by both the RTL and the software model.
package hpu_pkg;

    localparam int DIM_DEF   = 1023;  // MSB index of a hypervector
    localparam int CNT_W_DEF = 8;     // per-bit and vector counter width
    localparam int MAJ_W     = 32;    // operand width of the majority helper

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Bit-wise majority: 1 when more than half of n vectors had a one,
    // the tie bit on an exact half, otherwise 0.
    function automatic logic majority_bit(input logic [MAJ_W-1:0] count,
                                          input logic [MAJ_W-1:0] num,
                                          input logic             tie);
        logic [MAJ_W:0] twice;
        logic [MAJ_W:0] num_w;
        logic           res;
        twice = {count, 1'b0};
        num_w = {1'b0, num};
        if (twice > num_w) begin
            res = 1'b1;
        end else if (twice == num_w) begin
            res = tie;
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/hv_bundle_bit_counter.sv
// One bit lane of the bundler: counts ones seen on this bit position and
// produces the majority bit that would result if the current vector closes
// the sequence.
module hv_bit_counter
    import hpu_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,   // freeze the lane (exec low)
    input  logic             clr,    // zero the lane; wins over inc
    input  logic             inc,    // accepted vector carries a one here
    input  logic [CNT_W:0]   num,    // vectors in the sequence incl. current
    input  logic             tie,    // tie-break bit for an exact half
    output logic             maj
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   sum;

    // Count ones in this lane; cleared at sequence end or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!hold) begin
            if (clr) begin
                cnt <= '0;
            end else if (inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Majority over the stored count plus the vector being presented now.
    always_comb begin
        sum = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
        maj = majority_bit(MAJ_W'(sum), MAJ_W'(num), tie);
    end

endmodule

// File: rtl/hv_bundle.sv
// Hypervector bundler: optionally binds each incoming permuted vector with a
// second operand, accumulates per-bit ones counts over a sequence and emits
// the bit-wise majority on the last vector. exec freezes everything so the
// controller can stall this block together with the permute stage.
//
// Handshake: no backpressure. A vector is taken on any edge with exec=1,
// in_valid=1, clear=0 and ovf=0 (and the vector counter not saturated);
// out_valid is a single-cycle pulse one edge after the last vector is taken,
// held (with out_data/out_num) while exec is low.
module hv_bundle
    import hpu_pkg::*;
#(
    parameter int DIM   = DIM_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exec,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [DIM:0]     in_data,
    input  logic             bind_en,
    input  logic [DIM:0]     bind_data,
    output logic             out_valid,
    output logic [DIM:0]     out_data,
    output logic [CNT_W-1:0] out_num,
    output logic             busy,
    output logic             ovf,
    output state_e           dbg_state
);

    localparam logic [CNT_W-1:0] VEC_MAX = '1;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] vec_cnt;
    logic [DIM:0]     tie_reg;
    logic [DIM:0]     v;
    logic [DIM:0]     tie_vec;
    logic [DIM:0]     maj_vec;
    logic [DIM:0]     lane_inc;
    logic [CNT_W:0]   num_next;
    logic             offer;
    logic             ovf_hit;
    logic             accept;
    logic             accept_last;
    logic             accept_plain;
    logic             lane_clr;
    logic             lane_hold;

    // Effective vector, acceptance qualification and tie source.
    always_comb begin
        v            = bind_en ? (in_data ^ bind_data) : in_data;
        offer        = exec && in_valid && !clear && !ovf;
        ovf_hit      = offer && (vec_cnt == VEC_MAX);
        accept       = offer && !ovf_hit;
        accept_last  = accept && in_last;
        accept_plain = accept && !in_last;
        num_next     = {1'b0, vec_cnt} + {{CNT_W{1'b0}}, 1'b1};
        // First vector of a sequence breaks its own ties.
        tie_vec      = (vec_cnt == '0) ? v : tie_reg;
        lane_inc     = {(DIM+1){accept}} & v;
        lane_clr     = clear || accept_last;
        lane_hold    = !exec;
    end

    for (genvar i = 0; i <= DIM; i++) begin : g_lane
        hv_bit_counter #(
            .CNT_W (CNT_W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .hold (lane_hold),
            .clr  (lane_clr),
            .inc  (lane_inc[i]),
            .num  (num_next),
            .tie  (tie_vec[i]),
            .maj  (maj_vec[i])
        );
    end

    // Vector counter and tie register for the sequence in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_cnt <= '0;
            tie_reg <= '0;
        end else if (exec) begin
            if (clear || accept_last) begin
                vec_cnt <= '0;
                tie_reg <= '0;
            end else if (accept_plain) begin
                vec_cnt <= vec_cnt + 1'b1;
                if (vec_cnt == '0) begin
                    tie_reg <= v;
                end
            end
        end
    end

    // Sticky overflow: set when a vector arrives at a saturated counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (exec) begin
            if (clear) begin
                ovf <= 1'b0;
            end else if (ovf_hit) begin
                ovf <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: enter ACCUM on a non-final vector, leave on last or clear.
    always_comb begin
        state_d = state_q;
        if (exec) begin
            if (clear) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE:    if (accept_plain) state_d = ACCUM;
                    ACCUM:   if (accept_last)  state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign busy      = (state_q == ACCUM);
    assign dbg_state = state_q;

    // Result register: one-cycle pulse after the last vector, held under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_num   <= '0;
        end else if (exec) begin
            out_valid <= accept_last;
            if (accept_last) begin
                out_data <= maj_vec;
                out_num  <= num_next[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_hv_bundle.sv
// Directed bench for hv_bundle: full-size instance with a scoreboard monitor,
// plus a small-counter instance for saturation behaviour.
module tb_hv_bundle;
    import hpu_pkg::*;

    localparam int W   = 1024;
    localparam int OW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic exec = 1'b1;

    // main instance
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          bind_en = 1'b0;
    logic [W-1:0]  bind_data = '0;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [7:0]    out_num;
    logic          busy;
    logic          ovf;
    state_e        dbg_state;

    // saturation instance
    logic          o_clear = 1'b0;
    logic          o_in_valid = 1'b0;
    logic          o_in_last = 1'b0;
    logic [OW-1:0] o_in_data = '0;
    logic          o_bind_en = 1'b0;
    logic [OW-1:0] o_bind_data = '0;
    logic          o_out_valid;
    logic [OW-1:0] o_out_data;
    logic [1:0]    o_out_num;
    logic          o_busy;
    logic          o_ovf;
    state_e        o_dbg_state;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    logic last_exec = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [7:0]   exp_num_q[$];

    hv_bundle u_dut (
        .clk       (clk),
        .rst       (rst),
        .exec      (exec),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .bind_en   (bind_en),
        .bind_data (bind_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_num   (out_num),
        .busy      (busy),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    hv_bundle #(.DIM(OW-1), .CNT_W(2)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .exec      (exec),
        .clear     (o_clear),
        .in_valid  (o_in_valid),
        .in_last   (o_in_last),
        .in_data   (o_in_data),
        .bind_en   (o_bind_en),
        .bind_data (o_bind_data),
        .out_valid (o_out_valid),
        .out_data  (o_out_data),
        .out_num   (o_out_num),
        .busy      (o_busy),
        .ovf       (o_ovf),
        .dbg_state (o_dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    always @(posedge clk) last_exec <= exec;

    // scoreboard monitor: one pop per fresh out_valid pulse
    always @(negedge clk) begin
        if (out_valid && last_exec && !rst) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: out_valid=1 with no expected result, out_data[63:0]=%h", out_data[63:0]);
            end else begin
                logic [W-1:0] ed;
                logic [7:0]   en;
                ed = exp_q.pop_front();
                en = exp_num_q.pop_front();
                checks += 2;
                if (out_data !== ed) begin
                    errors++;
                    $display("FAIL out_data: got[127:0]=%h want[127:0]=%h upper_equal=%0b",
                             out_data[127:0], ed[127:0], out_data[W-1:128] === ed[W-1:128]);
                end
                if (out_num !== en) begin
                    errors++;
                    $display("FAIL out_num: got=%0d want=%0d", out_num, en);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // driver tasks: present a vector for one edge, return just after it
    task automatic send(input logic [W-1:0] d, input logic last,
                        input logic be, input logic [W-1:0] bd);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        bind_en   = be;
        bind_data = bd;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        bind_en  = 1'b0;
    endtask

    task automatic o_send(input logic [OW-1:0] d, input logic last);
        o_in_valid = 1'b1;
        o_in_data  = d;
        o_in_last  = last;
        @(posedge clk);
        #1;
        o_in_valid = 1'b0;
        o_in_last  = 1'b0;
    endtask

    task automatic expect_out(input logic [W-1:0] d, input logic [7:0] n);
        exp_q.push_back(d);
        exp_num_q.push_back(n);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(|out_data), 64'd0);
        check("rst_out_num", 64'(out_num), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sat_ovf", 64'(o_ovf), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // majority of three vectors
        send(W'(8'hF0), 1'b0, 1'b0, '0);
        @(negedge clk);
        check("busy_after_first", 64'(busy), 64'd1);
        check("state_accum", 64'(dbg_state), 64'(ACCUM));
        send(W'(8'hFF), 1'b0, 1'b0, '0);
        expect_out(W'(8'hF0), 8'd3);
        send(W'(8'h00), 1'b1, 1'b0, '0);
        @(negedge clk);
        check("busy_after_last", 64'(busy), 64'd0);
        @(negedge clk);
        check("out_valid_one_cycle", 64'(out_valid), 64'd0);

        // ties resolved from the first vector
        send(W'(4'h5), 1'b0, 1'b0, '0);
        expect_out(W'(4'h5), 8'd2);
        send(W'(4'h3), 1'b1, 1'b0, '0);

        // single bound vector, then a back-to-back single vector
        expect_out({512{2'b01}}, 8'd1);
        send('1, 1'b1, 1'b1, {512{2'b10}});
        expect_out(W'(16'h1234), 8'd1);
        send(W'(16'h1234), 1'b1, 1'b0, '0);
        @(negedge clk);
        check("b2b_out_valid", 64'(out_valid), 64'd1);
        check("b2b_out_num", 64'(out_num), 64'd1);

        // four vectors with a stall after the second one
        send(W'(8'h0F), 1'b0, 1'b0, '0);
        send(W'(8'h33), 1'b0, 1'b0, '0);
        exec     = 1'b0;
        in_valid = 1'b1;
        in_data  = W'(8'h55);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("stall_busy", 64'(busy), 64'd1);
        exec = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        expect_out(W'(8'h1F), 8'd4);
        send(W'(8'hFF), 1'b1, 1'b0, '0);
        exec = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("stall_hold_valid", 64'(out_valid), 64'd1);
            check("stall_hold_num", 64'(out_num), 64'd4);
        end
        exec = 1'b1;
        @(negedge clk);
        check("stall_release_valid", 64'(out_valid), 64'd0);

        // clear with the third vector of a sequence
        send(W'(8'h01), 1'b0, 1'b0, '0);
        send(W'(8'h02), 1'b0, 1'b0, '0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = W'(8'h04);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("clear_busy", 64'(busy), 64'd0);
        check("clear_out_valid", 64'(out_valid), 64'd0);
        expect_out(W'(16'hBEEF), 8'd1);
        send(W'(16'hBEEF), 1'b1, 1'b0, '0);

        // saturation on a 2-bit counter
        o_send(16'h0001, 1'b0);
        o_send(16'h0001, 1'b0);
        o_send(16'h0001, 1'b0);
        @(negedge clk);
        check("sat_busy", 64'(o_busy), 64'd1);
        check("sat_no_ovf_yet", 64'(o_ovf), 64'd0);
        o_send(16'h0001, 1'b1);
        @(negedge clk);
        check("sat_ovf_set", 64'(o_ovf), 64'd1);
        check("sat_no_output", 64'(o_out_valid), 64'd0);
        o_send(16'h0002, 1'b1);
        @(negedge clk);
        check("sat_last_ignored", 64'(o_out_valid), 64'd0);
        check("sat_ovf_sticky", 64'(o_ovf), 64'd1);
        o_clear = 1'b1;
        @(posedge clk);
        #1;
        o_clear = 1'b0;
        @(negedge clk);
        check("sat_clear_ovf", 64'(o_ovf), 64'd0);
        check("sat_clear_busy", 64'(o_busy), 64'd0);
        o_send(16'h00A5, 1'b1);
        @(negedge clk);
        check("sat_after_valid", 64'(o_out_valid), 64'd1);
        check("sat_after_data", 64'(o_out_data), 64'h00A5);
        check("sat_after_num", 64'(o_out_num), 64'd1);

        // reset in the middle of a sequence
        send(W'(8'h01), 1'b0, 1'b0, '0);
        send(W'(8'h03), 1'b0, 1'b0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(|out_data), 64'd0);
        check("midrst_out_num", 64'(out_num), 64'd0);
        check("midrst_ovf", 64'(ovf), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        send(W'(8'h04), 1'b0, 1'b0, '0);
        expect_out(W'(8'h04), 8'd2);
        send(W'(8'h04), 1'b1, 1'b0, '0);

        // drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("pulse_count", 64'(pulses), 64'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
